// File: rtl/load_align_unit.sv
// Load alignment unit: issues word-aligned reads, splits loads that cross a word
// boundary into two reads, then extracts and sign/zero-extends the loaded value.
module load_align_unit #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_req,
   input  logic [2:0]        load_type,
   input  logic [ADDR_W-1:0] load_addr,
   output logic              ready,
   output logic              done,
   output logic [31:0]       load_data,
   output logic              load_err,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_address,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_resp
);

   typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, DONE} state_t;

   state_t            state;
   logic [2:0]        type_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [1:0]        off_q;
   logic [31:0]       lo_q;
   logic              legal_c;
   logic              split_c;

   // Shift the two-word window down by the byte offset, then extend by type.
   function automatic logic [31:0] merge(input logic [2:0]  t,
                                         input logic [1:0]  off,
                                         input logic [31:0] hi,
                                         input logic [31:0] lo);
      logic [31:0] s;
      s = 32'({hi, lo} >> {off, 3'b000});
      case (t)
         3'b000:  merge = {{24{s[7]}}, s[7:0]};
         3'b001:  merge = {{16{s[15]}}, s[15:0]};
         3'b100:  merge = {24'h0, s[7:0]};
         3'b101:  merge = {16'h0, s[15:0]};
         default: merge = s;
      endcase
   endfunction

   always_comb begin
      legal_c = (load_type == 3'b000) || (load_type == 3'b001) || (load_type == 3'b010) ||
                (load_type == 3'b100) || (load_type == 3'b101);
      // Halfwords cross only at offset 3; words cross at any non-zero offset.
      split_c = ((type_q[1:0] == 2'b01) && (off_q == 2'b11)) ||
                ((type_q[1:0] == 2'b10) && (off_q != 2'b00));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         ready       <= 1'b1;
         done        <= 1'b0;
         load_data   <= 32'h0;
         load_err    <= 1'b0;
         mem_read    <= 1'b0;
         mem_address <= '0;
         type_q      <= 3'b000;
         waddr_q     <= '0;
         off_q       <= 2'b00;
         lo_q        <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (load_req) begin
                  type_q  <= load_type;
                  waddr_q <= {load_addr[ADDR_W-1:2], 2'b00};
                  off_q   <= load_addr[1:0];
                  lo_q    <= 32'h0;
                  ready   <= 1'b0;
                  if (!legal_c) begin
                     state     <= DONE;
                     done      <= 1'b1;
                     load_err  <= 1'b1;
                     load_data <= 32'h0;
                  end else begin
                     state       <= RD_LO;
                     mem_read    <= 1'b1;
                     mem_address <= {load_addr[ADDR_W-1:2], 2'b00};
                  end
               end
            end
            RD_LO: begin
               if (mem_resp) begin
                  lo_q     <= mem_rdata;
                  mem_read <= 1'b0;
                  if (split_c) begin
                     state <= RD_HI;
                  end else begin
                     state     <= DONE;
                     done      <= 1'b1;
                     load_err  <= 1'b0;
                     load_data <= merge(type_q, off_q, 32'h0, mem_rdata);
                  end
               end
            end
            RD_HI: begin
               // First cycle here is the mandatory idle gap between the two reads.
               if (!mem_read) begin
                  mem_read    <= 1'b1;
                  mem_address <= waddr_q + ADDR_W'(4);
               end else if (mem_resp) begin
                  mem_read  <= 1'b0;
                  state     <= DONE;
                  done      <= 1'b1;
                  load_err  <= 1'b0;
                  load_data <= merge(type_q, off_q, mem_rdata, lo_q);
               end
            end
            DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: directed and random loads against a byte-level model,
// with the bench acting as the memory.
module tb_load_align_unit;
   localparam int unsigned ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              load_req;
   logic [2:0]        load_type;
   logic [ADDR_W-1:0] load_addr;
   logic              ready;
   logic              done;
   logic [31:0]       load_data;
   logic              load_err;
   logic              mem_read;
   logic [ADDR_W-1:0] mem_address;
   logic [31:0]       mem_rdata;
   logic              mem_resp;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_align_unit #(.ADDR_W(ADDR_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_req    (load_req),
      .load_type   (load_type),
      .load_addr   (load_addr),
      .ready       (ready),
      .done        (done),
      .load_data   (load_data),
      .load_err    (load_err),
      .mem_read    (mem_read),
      .mem_address (mem_address),
      .mem_rdata   (mem_rdata),
      .mem_resp    (mem_resp)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Byte-level model: memory bytes at addr..addr+n-1 taken from two consecutive words.
   function automatic void ref_load(input logic [2:0] t, input logic [31:0] a,
                                    input logic [31:0] w0, input logic [31:0] w1,
                                    output logic err, output logic [31:0] data,
                                    output int nreads);
      logic [7:0]  b [8];
      int          n;
      logic [31:0] v;
      for (int i = 0; i < 4; i++) begin
         b[i]   = w0[8*i +: 8];
         b[i+4] = w1[8*i +: 8];
      end
      err = 1'b0; data = 32'h0; nreads = 0;
      case (t)
         3'b000, 3'b100: n = 1;
         3'b001, 3'b101: n = 2;
         3'b010:         n = 4;
         default:        n = 0;
      endcase
      if (n == 0) begin
         err = 1'b1;
         return;
      end
      v = 32'h0;
      for (int k = 0; k < n; k++) v = v | (32'(b[int'(a[1:0]) + k]) << (8*k));
      if (!t[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      data   = v;
      nreads = (int'(a[1:0]) + n > 4) ? 2 : 1;
   endfunction

   // Issue one load and serve its memory reads; called at a negedge with ready high.
   task automatic do_load(input string tag, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] w0, input logic [31:0] w1, input int lat,
                          input bit hold_req, input bit abort_hi);
      logic        e_err;
      logic [31:0] e_data;
      int          e_n;
      logic [31:0] base;
      int          nrd, wcnt;
      bit          prev_resp, resp_now, got;
      ref_load(t, a, w0, w1, e_err, e_data, e_n);
      base = {a[31:2], 2'b00};
      check({tag, "_ready_idle"}, 32'(ready), 32'd1);
      load_req = 1'b1; load_type = t; load_addr = a;
      @(negedge clk);
      if (hold_req) load_addr = a ^ 32'h0000_5000;
      else load_req = 1'b0;
      nrd = 0; wcnt = 0; prev_resp = 1'b0; got = 1'b0;
      for (int c = 0; c < 40; c++) begin
         resp_now = 1'b0;
         mem_resp = 1'b0;
         if (c == 0) begin
            if (e_err) check({tag, "_done_lat"}, 32'(done), 32'd1);
            else       check({tag, "_read_lat"}, 32'(mem_read), 32'd1);
         end
         if (prev_resp) begin
            if (nrd == e_n) check({tag, "_done_after_resp"}, 32'(done), 32'd1);
            else            check({tag, "_read_gap"}, 32'(mem_read), 32'd0);
         end
         if (done) begin
            got = 1'b1;
            break;
         end
         if (mem_read) begin
            check({tag, "_addr"}, mem_address, (nrd == 0) ? base : base + 32'd4);
            check({tag, "_ready_busy"}, 32'(ready), 32'd0);
            if (abort_hi && nrd == 1) return;
            if (wcnt == lat) begin
               mem_resp  = 1'b1;
               mem_rdata = (nrd == 0) ? w0 : w1;
               nrd++;
               wcnt = 0;
               resp_now = 1'b1;
            end else begin
               wcnt++;
            end
         end
         prev_resp = resp_now;
         @(negedge clk);
      end
      load_req = 1'b0;
      mem_resp = 1'b0;
      check({tag, "_timeout"}, 32'(got), 32'd1);
      if (got) begin
         check({tag, "_data"}, load_data, e_data);
         check({tag, "_err"}, 32'(load_err), 32'(e_err));
         check({tag, "_nreads"}, 32'(nrd), 32'(e_n));
         check({tag, "_read_off"}, 32'(mem_read), 32'd0);
      end
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_ready_back"}, 32'(ready), 32'd1);
      check({tag, "_data_hold"}, load_data, e_data);
   endtask

   initial begin
      logic [2:0]  rt;
      logic [31:0] ra, rw0, rw1;
      rst_n = 1'b0; load_req = 1'b0; load_type = 3'b000; load_addr = 32'h0;
      mem_rdata = 32'h0; mem_resp = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_read", 32'(mem_read), 32'd0);
      check("rst_data", load_data, 32'h0);
      check("rst_err", 32'(load_err), 32'd0);
      check("rst_addr", mem_address, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Stray response while idle.
      mem_resp = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      mem_resp = 1'b0;
      check("idle_resp_done", 32'(done), 32'd0);
      check("idle_resp_read", 32'(mem_read), 32'd0);
      check("idle_resp_ready", 32'(ready), 32'd1);

      do_load("lb_1003", 3'b000, 32'h0000_1003, 32'h80FF_1234, 32'h0, 2, 1'b0, 1'b0);
      check("lb_1003_const", load_data, 32'hFFFF_FF80);
      do_load("lhu_2002", 3'b101, 32'h0000_2002, 32'hBEEF_0000, 32'h0, 1, 1'b0, 1'b0);
      check("lhu_2002_const", load_data, 32'h0000_BEEF);
      do_load("lh_2002", 3'b001, 32'h0000_2002, 32'hBEEF_0000, 32'h0, 0, 1'b0, 1'b0);
      check("lh_2002_const", load_data, 32'hFFFF_BEEF);
      do_load("lw_3001", 3'b010, 32'h0000_3001, 32'h4433_2211, 32'h8877_6655, 1, 1'b0, 1'b0);
      check("lw_3001_const", load_data, 32'h5544_3322);
      do_load("lh_wrap", 3'b001, 32'hFFFF_FFFF, 32'h00AA_0000, 32'h0000_00BB, 0, 1'b0, 1'b0);
      check("lh_wrap_const", load_data, 32'hFFFF_BB00);
      do_load("illegal", 3'b011, 32'h0000_0040, 32'h1111_1111, 32'h0, 0, 1'b0, 1'b0);
      check("illegal_err_const", 32'(load_err), 32'd1);
      do_load("held_req", 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 32'h0, 2, 1'b1, 1'b0);

      // Reset while the second read of a split load is outstanding.
      do_load("abort", 3'b010, 32'h0000_3001, 32'h4433_2211, 32'h8877_6655, 1, 1'b0, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_read", 32'(mem_read), 32'd0);
      check("abort_ready", 32'(ready), 32'd1);
      check("abort_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      mem_resp = 1'b1; mem_rdata = 32'h8877_6655;
      @(negedge clk);
      mem_resp = 1'b0;
      check("late_resp_done", 32'(done), 32'd0);
      check("late_resp_read", 32'(mem_read), 32'd0);
      check("late_resp_data", load_data, 32'h0);
      do_load("lw_0", 3'b010, 32'h0000_0000, 32'h1234_5678, 32'h0, 1, 1'b0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         rt  = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rw0 = $urandom;
         rw1 = $urandom;
         do_load("rand", rt, ra, rw0, rw1, int'($urandom_range(0, 3)), 1'b0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
